// File: rtl/elink_trig_frame_sync_if.sv
// Voted trigger word stream in, aligned payload and link status out.
interface elink_trig_frame_sync_if #(
   parameter int SEU_CNT_W = 16
);
   logic [11:0]          voted_in;
   logic                 in_valid;
   logic                 seu_clear;
   logic [9:0]           trig_data;
   logic                 trig_valid;
   logic                 trig_sof;
   logic                 locked;
   logic                 align_err;
   logic [SEU_CNT_W-1:0] seu_count;

   modport master (
      output voted_in, in_valid, seu_clear,
      input  trig_data, trig_valid, trig_sof, locked, align_err, seu_count
   );

   modport slave (
      input  voted_in, in_valid, seu_clear,
      output trig_data, trig_valid, trig_sof, locked, align_err, seu_count
   );
endinterface

// File: rtl/elink_trig_frame_sync.sv
// Frame aligner for the voted elink trigger stream: hunts for the sync header,
// verifies it, tracks lock with a flywheel and emits payload words.
module elink_trig_frame_sync #(
   parameter logic [9:0] SYNC_WORD  = 10'h3C5,
   parameter int         FRAME_LEN  = 4,
   parameter int         LOCK_CNT   = 3,
   parameter int         UNLOCK_CNT = 2,
   parameter int         SEU_CNT_W  = 16
) (
   input logic                    clk,
   input logic                    rst,
   elink_trig_frame_sync_if.slave lnk
);

   localparam int DATA_W = 10;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic [SEU_CNT_W-1:0] sat_inc(input logic [SEU_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [DATA_W-1:0]    data_p0;
   logic                 vld_p0;

   state_t               state_p1, state_nxt;
   logic [3:0]           slot_p1, slot_nxt, slot_wrap;
   logic [2:0]           good_p1, good_nxt, good_inc;
   logic [2:0]           bad_p1, bad_nxt, bad_inc;
   logic                 hdr_ok;

   logic                 emit_nxt, sof_nxt, err_nxt;
   logic [DATA_W-1:0]    trig_data_p1;
   logic                 trig_valid_p1, trig_sof_p1, align_err_p1, locked_p1;
   logic [SEU_CNT_W-1:0] seu_cnt;

   // The reserved voter bit is deliberately not consumed.
   logic                 unused_rsvd;
   assign unused_rsvd = lnk.voted_in[11];

   // ---- stage p0: input register
   always_ff @(posedge clk) begin
      if (rst) begin
         data_p0 <= '0;
         vld_p0  <= 1'b0;
      end else begin
         data_p0 <= lnk.voted_in[DATA_W-1:0];
         vld_p0  <= lnk.in_valid;
      end
   end

   // ---- stage p1: alignment state machine and output registers
   assign hdr_ok    = (data_p0 == SYNC_WORD);
   assign slot_wrap = (slot_p1 == 4'(FRAME_LEN)) ? 4'd0 : slot_p1 + 4'd1;
   assign good_inc  = good_p1 + 3'd1;
   assign bad_inc   = bad_p1 + 3'd1;

   always_comb begin
      state_nxt = state_p1;
      slot_nxt  = slot_p1;
      good_nxt  = good_p1;
      bad_nxt   = bad_p1;
      emit_nxt  = 1'b0;
      sof_nxt   = 1'b0;
      err_nxt   = 1'b0;

      if (vld_p0) begin
         case (state_p1)
            HUNT: begin
               if (hdr_ok) begin
                  slot_nxt = 4'd1;
                  bad_nxt  = 3'd0;
                  if (LOCK_CNT == 1) begin
                     state_nxt = LOCKED;
                     good_nxt  = 3'd0;
                  end else begin
                     state_nxt = VERIFY;
                     good_nxt  = 3'd1;
                  end
               end
            end

            VERIFY: begin
               slot_nxt = slot_wrap;
               if (slot_p1 == 4'd0) begin
                  if (!hdr_ok) begin
                     // Back to hunting; the bad word is not re-examined as a header.
                     state_nxt = HUNT;
                     good_nxt  = 3'd0;
                     slot_nxt  = 4'd0;
                  end else if (good_inc == 3'(LOCK_CNT)) begin
                     state_nxt = LOCKED;
                     good_nxt  = 3'd0;
                     bad_nxt   = 3'd0;
                  end else begin
                     good_nxt = good_inc;
                  end
               end
            end

            LOCKED: begin
               slot_nxt = slot_wrap;
               if (slot_p1 == 4'd0) begin
                  if (hdr_ok) begin
                     bad_nxt = 3'd0;
                  end else begin
                     err_nxt = 1'b1;
                     if (bad_inc == 3'(UNLOCK_CNT)) begin
                        state_nxt = HUNT;
                        bad_nxt   = 3'd0;
                        slot_nxt  = 4'd0;
                     end else begin
                        bad_nxt = bad_inc;
                     end
                  end
               end else begin
                  emit_nxt = 1'b1;
                  sof_nxt  = (slot_p1 == 4'd1);
               end
            end

            default: begin
               state_nxt = HUNT;
               slot_nxt  = 4'd0;
               good_nxt  = 3'd0;
               bad_nxt   = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1      <= HUNT;
         slot_p1       <= 4'd0;
         good_p1       <= 3'd0;
         bad_p1        <= 3'd0;
         trig_data_p1  <= '0;
         trig_valid_p1 <= 1'b0;
         trig_sof_p1   <= 1'b0;
         align_err_p1  <= 1'b0;
         locked_p1     <= 1'b0;
      end else begin
         state_p1      <= state_nxt;
         slot_p1       <= slot_nxt;
         good_p1       <= good_nxt;
         bad_p1        <= bad_nxt;
         trig_data_p1  <= emit_nxt ? data_p0 : '0;
         trig_valid_p1 <= emit_nxt;
         trig_sof_p1   <= sof_nxt;
         align_err_p1  <= err_nxt;
         locked_p1     <= (state_nxt == LOCKED);
      end
   end

   // SEU tally works on the raw input so a clear and a flagged word in the
   // same cycle resolve against each other directly.
   always_ff @(posedge clk) begin
      if (rst || lnk.seu_clear) begin
         seu_cnt <= '0;
      end else if (lnk.in_valid && lnk.voted_in[10]) begin
         seu_cnt <= sat_inc(seu_cnt);
      end
   end

   assign lnk.trig_data  = trig_data_p1;
   assign lnk.trig_valid = trig_valid_p1;
   assign lnk.trig_sof   = trig_sof_p1;
   assign lnk.align_err  = align_err_p1;
   assign lnk.locked     = locked_p1;
   assign lnk.seu_count  = seu_cnt;

endmodule

// File: tb/tb_elink_trig_frame_sync.sv
// Directed bench for elink_trig_frame_sync: lock, flywheel, unlock, false sync,
// SEU saturation/clear and mid-lock reset.
module tb_elink_trig_frame_sync;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   elink_trig_frame_sync_if #(.SEU_CNT_W(4)) ifc ();

   elink_trig_frame_sync #(
      .SYNC_WORD (10'h3C5),
      .FRAME_LEN (4),
      .LOCK_CNT  (3),
      .UNLOCK_CNT(2),
      .SEU_CNT_W (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .lnk(ifc)
   );

   int          n_cmp = 0;
   int          n_mis = 0;
   int          err_cnt = 0;
   logic [10:0] out_q[$];

   // Payload words ({sof, data}) and align_err pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (ifc.trig_valid) out_q.push_back({ifc.trig_sof, ifc.trig_data});
      if (ifc.align_err) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [11:0] w, input logic v);
      ifc.voted_in = w;
      ifc.in_valid = v;
      @(posedge clk);
      #1;
   endtask

   // Idle cycles carry a flagged header-like word to prove in_valid gates it.
   task automatic idle(input int n);
      repeat (n) step(12'h7C5, 1'b0);
   endtask

   task automatic send_frame(input logic [11:0] hdr, input logic [9:0] base, input int gap);
      step(hdr, 1'b1);
      idle(gap);
      for (int i = 1; i <= 4; i++) begin
         step({2'b00, base + 10'(i)}, 1'b1);
         idle(gap);
      end
   endtask

   task automatic check_frame(input string tag, input int idx, input logic [9:0] first);
      logic [10:0] got, want;
      for (int k = 0; k < 4; k++) begin
         got  = (idx + k < out_q.size()) ? out_q[idx + k] : 11'h7FF;
         want = {(k == 0), first + 10'(k)};
         check($sformatf("%s_w%0d", tag, k), 32'(got), 32'(want));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data"},  32'(ifc.trig_data),  0);
      check({tag, "_valid"}, 32'(ifc.trig_valid), 0);
      check({tag, "_sof"},   32'(ifc.trig_sof),   0);
      check({tag, "_lock"},  32'(ifc.locked),     0);
      check({tag, "_err"},   32'(ifc.align_err),  0);
      check({tag, "_seu"},   32'(ifc.seu_count),  0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(12'h000, 1'b0);
      rst = 1'b0;
   endtask

   int q0, q1, e0;

   initial begin
      rst           = 1'b1;
      ifc.voted_in  = '0;
      ifc.in_valid  = 1'b0;
      ifc.seu_clear = 1'b0;
      repeat (3) step(12'h000, 1'b0);
      rst = 1'b0;
      check_zero("rst");

      // 1: lock after three good headers, payload only from frame 3
      q0 = out_q.size();
      send_frame(12'h3C5, 10'h000, 0);
      send_frame(12'h3C5, 10'h000, 0);
      step(12'h3C5, 1'b1);
      check("t1_no_out", out_q.size() - q0, 0);
      check("t1_lock_pre", 32'(ifc.locked), 0);
      step(12'h001, 1'b1);
      check("t1_lock_rise", 32'(ifc.locked), 1);
      step(12'h002, 1'b1);
      step(12'h003, 1'b1);
      step(12'h004, 1'b1);
      idle(2);
      check("t1_n", out_q.size() - q0, 4);
      check_frame("t1", q0, 10'h001);

      // 2: single bad header flywheels; the next good header clears bad_cnt
      q0 = out_q.size();
      e0 = err_cnt;
      send_frame(12'h3C4, 10'h010, 0);
      send_frame(12'h3C5, 10'h020, 0);
      idle(2);
      check("t2_err", err_cnt - e0, 1);
      check("t2_lock", 32'(ifc.locked), 1);
      check("t2_n", out_q.size() - q0, 8);
      check_frame("t2a", q0, 10'h011);
      check_frame("t2b", q0 + 4, 10'h021);
      send_frame(12'h3C4, 10'h030, 0);
      send_frame(12'h3C5, 10'h040, 0);
      idle(2);
      check("t2_err2", err_cnt - e0, 2);
      check("t2_still_lock", 32'(ifc.locked), 1);

      // 3: two consecutive bad headers drop lock until three fresh headers
      q0 = out_q.size();
      e0 = err_cnt;
      send_frame(12'h3C4, 10'h050, 0);
      step(12'h3C0, 1'b1);
      step(12'h061, 1'b1);
      check("t3_err_pulse", 32'(ifc.align_err), 1);
      check("t3_fall", 32'(ifc.locked), 0);
      step(12'h062, 1'b1);
      step(12'h063, 1'b1);
      step(12'h064, 1'b1);
      send_frame(12'h3C5, 10'h070, 0);
      send_frame(12'h3C5, 10'h080, 0);
      send_frame(12'h3C5, 10'h090, 0);
      idle(2);
      check("t3_err", err_cnt - e0, 2);
      check("t3_n", out_q.size() - q0, 8);
      check_frame("t3a", q0, 10'h051);
      check_frame("t3b", q0 + 4, 10'h091);
      check("t3_relock", 32'(ifc.locked), 1);

      // 4: false sync falls back to HUNT at the bad header
      do_reset();
      q0 = out_q.size();
      step(12'h3C5, 1'b1);
      step(12'h010, 1'b1);
      step(12'h011, 1'b1);
      step(12'h012, 1'b1);
      step(12'h013, 1'b1);
      step(12'h0AA, 1'b1);
      send_frame(12'h3C5, 10'h020, 0);
      send_frame(12'h3C5, 10'h020, 0);
      idle(2);
      check("t4_lock", 32'(ifc.locked), 0);
      check("t4_n", out_q.size() - q0, 0);

      // 5: SEU counter saturation, clear priority, reserved bit, valid gating
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(12'h400 | 12'(i), 1'b1);
         if (i == 13) check("t5_14", 32'(ifc.seu_count), 14);
      end
      check("t5_sat", 32'(ifc.seu_count), 15);
      ifc.seu_clear = 1'b1;
      step(12'h400, 1'b1);
      ifc.seu_clear = 1'b0;
      check("t5_clr", 32'(ifc.seu_count), 0);
      step(12'h400, 1'b1);
      check("t5_inc", 32'(ifc.seu_count), 1);
      step(12'h800, 1'b1);
      check("t5_bit11", 32'(ifc.seu_count), 1);
      step(12'h400, 1'b0);
      check("t5_novld", 32'(ifc.seu_count), 1);

      // 6: sparse in_valid gives the same words; then reset while locked
      do_reset();
      q0 = out_q.size();
      send_frame(12'hFC5, 10'h000, 1);
      send_frame(12'hFC5, 10'h000, 1);
      send_frame(12'hFC5, 10'h000, 1);
      idle(2);
      check("t6_n", out_q.size() - q0, 4);
      check_frame("t6", q0, 10'h001);
      check("t6_lock", 32'(ifc.locked), 1);
      check("t6_seu", 32'(ifc.seu_count), 3);
      step(12'h3C5, 1'b1);
      step(12'h001, 1'b1);
      rst = 1'b1;
      step(12'h002, 1'b1);
      rst = 1'b0;
      check_zero("t6_rst");
      step(12'h003, 1'b1);
      check("t6_post_valid", 32'(ifc.trig_valid), 0);
      q1 = out_q.size();
      send_frame(12'h3C5, 10'h030, 0);
      send_frame(12'h3C5, 10'h040, 0);
      idle(2);
      check("t6_no_relock", 32'(ifc.locked), 0);
      send_frame(12'h3C5, 10'h050, 0);
      idle(2);
      check("t6_relock", 32'(ifc.locked), 1);
      check("t6_relock_n", out_q.size() - q1, 4);
      check_frame("t6r", q1, 10'h051);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
